byte_unstriping: RTL

//  Receive-side counterpart of the transmitter: takes the four striped lanes,

---
 rtl/byte_unstriping.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/byte_unstriping.sv
// Receive-side lane merger: deskews four striped lanes on COM through per-lane
// elastic FIFOs, then pops them round-robin 0,1,2,3 into one tagged byte stream.
module byte_unstriping #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_SKEW = 8,
    parameter logic [7:0]  K_COM    = 8'hBC,
    parameter logic [7:0]  K_SKP    = 8'h1C,
    parameter logic [7:0]  K_STP    = 8'hFB,
    parameter logic [7:0]  K_SDP    = 8'h5C,
    parameter logic [7:0]  K_END    = 8'hFD,
    parameter logic [7:0]  K_EDB    = 8'hFE,
    parameter logic [7:0]  K_FTS    = 8'h3C,
    parameter logic [7:0]  K_IDL    = 8'h7C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] rx_lane0,
    input  logic [7:0] rx_lane1,
    input  logic [7:0] rx_lane2,
    input  logic [7:0] rx_lane3,
    input  logic [3:0] rx_lane_valid,
    input  logic [3:0] rx_lane_k,
    output logic [7:0] rx_Data,
    output logic       rx_Valid,
    output logic [3:0] rx_control_dk,
    output logic       rx_aligned,
    output logic       rx_align_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(MAX_SKEW + 1);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [SW-1:0] SKEW_LAST = SW'(MAX_SKEW - 1);

    typedef enum logic {S_ALIGN, S_MERGE} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_aligned, w_aligned_nxt;
    logic [SW-1:0] r_skew, w_skew_nxt;
    logic [1:0]    r_rd_lane, w_rd_lane_nxt;

    logic [8:0]    r_mem [4][DEPTH];
    logic [AW:0]   r_wptr [4];
    logic [AW:0]   r_rptr [4];

    logic [7:0]    r_data;
    logic [3:0]    r_dk;
    logic          r_valid;
    logic          r_err;

    logic [7:0]    w_byte [4];
    logic [3:0]    w_full, w_empty, w_com_hit, w_wr, w_ovf_lane;
    logic          w_pop, w_overflow, w_timeout, w_flush;
    logic [8:0]    w_pop_entry;

    function automatic logic [3:0] f_code(input logic [8:0] e);
        if (!e[8]) return 4'd0;
        case (e[7:0])
            K_COM:   return 4'd1;
            K_SKP:   return 4'd2;
            K_STP:   return 4'd3;
            K_SDP:   return 4'd4;
            K_END:   return 4'd5;
            K_EDB:   return 4'd6;
            K_FTS:   return 4'd7;
            K_IDL:   return 4'd8;
            default: return 4'd15;
        endcase
    endfunction

    always_comb begin
        w_byte[0] = rx_lane0;
        w_byte[1] = rx_lane1;
        w_byte[2] = rx_lane2;
        w_byte[3] = rx_lane3;
    end

    // Unaligned lanes in ALIGN only accept the COM that aligns them.
    always_comb begin
        w_full     = '0;
        w_empty    = '0;
        w_com_hit  = '0;
        w_wr       = '0;
        w_ovf_lane = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_empty[i]   = (r_wptr[i] == r_rptr[i]);
            w_full[i]    = (r_wptr[i][AW] != r_rptr[i][AW]) &&
                           (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
            w_com_hit[i] = rx_lane_valid[i] & rx_lane_k[i] & (w_byte[i] == K_COM);
            w_wr[i]      = enb & rx_lane_valid[i] &
                           ((r_state == S_MERGE) | r_aligned[i] | w_com_hit[i]);
        end
        w_pop = enb & (r_state == S_MERGE) & ~w_empty[r_rd_lane];
        for (int unsigned i = 0; i < 4; i++)
            w_ovf_lane[i] = w_wr[i] & w_full[i] & ~(w_pop & (r_rd_lane == 2'(i)));
        w_overflow  = |w_ovf_lane;
        w_pop_entry = r_mem[r_rd_lane][r_rptr[r_rd_lane][AW-1:0]];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_aligned_nxt = r_aligned;
        w_skew_nxt    = r_skew;
        w_rd_lane_nxt = r_rd_lane;
        w_timeout     = 1'b0;
        if (enb) begin
            if (w_overflow) begin
                w_state_nxt   = S_ALIGN;
                w_aligned_nxt = '0;
                w_skew_nxt    = '0;
                w_rd_lane_nxt = '0;
            end else if (r_state == S_ALIGN) begin
                if (r_aligned == 4'hF) begin
                    w_state_nxt   = S_MERGE;
                    w_skew_nxt    = '0;
                    w_rd_lane_nxt = '0;
                end else begin
                    if (r_aligned != '0) begin
                        if (r_skew == SKEW_LAST) w_timeout  = 1'b1;
                        else                     w_skew_nxt = r_skew + SW'(1);
                    end
                    if (w_timeout) begin
                        w_aligned_nxt = '0;
                        w_skew_nxt    = '0;
                    end else begin
                        w_aligned_nxt = r_aligned | w_com_hit;
                    end
                end
            end else if (w_pop) begin
                w_rd_lane_nxt = r_rd_lane + 2'd1;
            end
        end
        w_flush = w_overflow | w_timeout;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_ALIGN;
            r_aligned <= '0;
            r_skew    <= '0;
            r_rd_lane <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_aligned <= w_aligned_nxt;
            r_skew    <= w_skew_nxt;
            r_rd_lane <= w_rd_lane_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++)
            if (w_wr[i]) r_mem[i][r_wptr[i][AW-1:0]] <= {rx_lane_k[i], w_byte[i]};
    end

    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_wr[i]) r_wptr[i] <= r_wptr[i] + PTR_ONE;
                if (w_pop && (r_rd_lane == 2'(i))) r_rptr[i] <= r_rptr[i] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_dk    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_pop;
            r_err   <= w_flush;
            if (w_pop) begin
                r_data <= w_pop_entry[7:0];
                r_dk   <= f_code(w_pop_entry);
            end
        end
    end

    assign rx_Data       = r_data;
    assign rx_control_dk = r_dk;
    assign rx_Valid      = r_valid;
    assign rx_align_err  = r_err;
    assign rx_aligned    = (r_state == S_MERGE);

endmodule
